phi_state2serial: RTL and testbench
===================================

Name: phi_state2serial

Overview:
- Parallel-to-serial transmitter for the oscillator network's 60-bit phase vector (15 neurons x 4-bit phase). It is the return path of the serial state loader.
- Captures a phase snapshot on a start request.
- Emits the snapshot one bit per sclk, framed by a sync bit and an optional even-parity bit, so off-chip logic or a host link can read back network state after settling.

Parameters:
- WIDTH, 60, number of phase bits per frame.
- PARITY_EN, 1, 1 = append even-parity bit after data; 0 = no parity bit.
- CNT_W, 6, data-bit counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- sclk  input  1  system clock; all state changes on rising edge.
- re  input  1  reset; asynchronous, active-high.
- start  input  1  frame request; sampled only in IDLE.
- phi_in  input  [0:WIDTH-1]  phase vector to transmit; bit 0 = neuron 0 phase MSB.
- data_out  output  1  serial bit; 0 whenever sout_valid=0.
- sout_valid  output  1  high for every transmitted bit (sync, data, parity).
- frame_start  output  1  high only during the sync-bit cycle.
- busy  output  1  high from SYNC through PARITY inclusive.
- done  output  1  one-cycle pulse after the last transmitted bit.

Behaviour:
- Reset (re=1, async): FSM=IDLE, shadow register=0, counter=0, parity accumulator=0.
- Reset values of outputs: data_out=0, sout_valid=0, frame_start=0, busy=0, done=0.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, SYNC, SHIFT, PARITY, DONE.
- IDLE:
  - Outputs all 0.
  - On an edge with start=1: shadow <= phi_in, counter <= 0, parity <= 0, next = SYNC.
- SYNC (1 cycle): data_out=1, sout_valid=1, frame_start=1, busy=1. Next = SHIFT.
- SHIFT (WIDTH cycles):
  - data_out=shadow[counter], sout_valid=1, busy=1.
  - parity accumulates the XOR of each transmitted bit.
  - counter increments by 1 per cycle.
  - When counter==WIDTH-1: next = PARITY if PARITY_EN=1, else DONE.
  - Bit order: index 0 first, index WIDTH-1 last.
- PARITY (1 cycle, only if PARITY_EN=1): data_out = XOR of all WIDTH data bits (even parity over data only; sync bit excluded). sout_valid=1, busy=1. Next = DONE.
- DONE (1 cycle): done=1, sout_valid=0, busy=0, data_out=0. Next = IDLE.
- Latency: start sampled at edge k; frame_start visible after edge k+1; first data bit after edge k+2; done after edge k+2+WIDTH+PARITY_EN.
- Frame length: 1+WIDTH+PARITY_EN valid cycles, i.e. 62 at defaults.
- Snapshot isolation: changes on phi_in after the capture edge do not affect the frame in flight.
- start in SYNC/SHIFT/PARITY/DONE: ignored, not queued.
- start held high continuously: back-to-back frames with exactly 2 non-valid cycles (DONE, IDLE) between the last bit and the next sync. Period = WIDTH+PARITY_EN+3 = 64 cycles at defaults.
- Reset mid-frame: outputs drop to reset values immediately (async). No done pulse. Next frame starts only on a fresh start sampled in IDLE.
- Counter wrap: the counter never exceeds WIDTH-1; it is cleared on leaving SHIFT.

Test Plan:
- Reset check: assert re mid-simulation with random inputs -> all five outputs 0 within the same cycle; FSM in IDLE; no done pulse.
- Single frame, only phi_in[0]=1, other bits 0, PARITY_EN=1, start pulsed 1 cycle -> sout_valid high for 62 cycles; bit sequence = 1 (sync), 1, 59x0, parity=1; frame_start on cycle 1 only; done on cycle 63 after start.
- All ones (phi_in = 60 ones) -> 60 data bits = 1; parity = 0 (60 is even); busy high exactly 62 cycles.
- Pattern phi_in[0:7]=1011_0010, rest 0 -> serial data bits 1,0,1,1,0,0,1,0, then 52 zeros; parity = 0 (four ones). Change phi_in to all ones 5 cycles into the frame -> transmitted bits unchanged.
- start held high for 200 cycles -> 3 complete frames; each sync bit 64 cycles after the previous sync; exactly 2 invalid cycles between frames; start pulses during busy produce no extra frame.
- Reset asserted during data bit 30 -> immediate idle outputs, no done. Then release re and pulse start -> fresh complete 62-bit frame of the new phi_in.

Source files
------------

// File: rtl/phi_state2serial_if.sv
// Handshake/bus bundle for the phase-vector serial transmitter.
// The master drives the frame request and snapshot; the slave returns the serial stream.
interface phi_state2serial_if #(
  parameter int unsigned WIDTH = 60
);
  logic             start;
  logic [0:WIDTH-1] phi_in;
  logic             data_out;
  logic             sout_valid;
  logic             frame_start;
  logic             busy;
  logic             done;

  modport master (
    output start, phi_in,
    input  data_out, sout_valid, frame_start, busy, done
  );

  modport slave (
    input  start, phi_in,
    output data_out, sout_valid, frame_start, busy, done
  );
endinterface

// File: rtl/phi_state2serial.sv
// Serialises a captured 60-bit phase snapshot as: sync bit, data bits (index 0 first),
// optional even-parity bit, then a one-cycle done pulse. Outputs are registered from state.
module phi_state2serial #(
  parameter int unsigned WIDTH     = 60,
  parameter bit          PARITY_EN = 1'b1,
  parameter int unsigned CNT_W     = 6
) (
  input  logic               sclk,
  input  logic               re,
  phi_state2serial_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  if ((64'd1 << CNT_W) < 64'(WIDTH)) begin : g_cnt_check
    $error("CNT_W too narrow for WIDTH");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_SHIFT,
    S_PARITY,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [0:WIDTH-1] shadow, shadow_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             par, par_n;

  logic data_q, valid_q, fs_q, busy_q, done_q;
  logic data_n, valid_n, fs_n, busy_n, done_n;

  // State and datapath registers
  always_ff @(posedge sclk or posedge re) begin
    if (re) begin
      state  <= S_IDLE;
      shadow <= '0;
      cnt    <= '0;
      par    <= 1'b0;
    end else begin
      state  <= state_n;
      shadow <= shadow_n;
      cnt    <= cnt_n;
      par    <= par_n;
    end
  end

  // Next state, datapath update and decoded outputs for the current state
  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    cnt_n    = cnt;
    par_n    = par;
    data_n   = 1'b0;
    valid_n  = 1'b0;
    fs_n     = 1'b0;
    busy_n   = 1'b0;
    done_n   = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          shadow_n = bus.phi_in;
          cnt_n    = '0;
          par_n    = 1'b0;
          state_n  = S_SYNC;
        end
      end
      S_SYNC: begin
        data_n  = 1'b1;
        valid_n = 1'b1;
        fs_n    = 1'b1;
        busy_n  = 1'b1;
        state_n = S_SHIFT;
      end
      S_SHIFT: begin
        data_n  = shadow[cnt];
        valid_n = 1'b1;
        busy_n  = 1'b1;
        par_n   = par ^ shadow[cnt];
        if (cnt == LAST) begin
          cnt_n   = '0;
          state_n = PARITY_EN ? S_PARITY : S_DONE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_PARITY: begin
        // accumulator already holds the XOR of all data bits
        data_n  = par;
        valid_n = 1'b1;
        busy_n  = 1'b1;
        state_n = S_DONE;
      end
      S_DONE: begin
        done_n  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output registers: one cycle behind the state they decode
  always_ff @(posedge sclk or posedge re) begin
    if (re) begin
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      data_q  <= data_n;
      valid_q <= valid_n;
      fs_q    <= fs_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  assign bus.data_out    = data_q;
  assign bus.sout_valid  = valid_q;
  assign bus.frame_start = fs_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_phi_state2serial.sv
// Directed bench for phi_state2serial: frame shape, data order, parity, snapshot
// isolation, ignored start requests, back-to-back frames and mid-frame reset.
module tb_phi_state2serial;

  localparam int unsigned W  = 60;
  localparam int unsigned NC = 66;
  localparam int unsigned NB = 200;

  logic sclk;
  logic re;
  int   total;
  int   bad;

  phi_state2serial_if #(.WIDTH(W)) bus ();

  phi_state2serial #(.WIDTH(W), .PARITY_EN(1'b1), .CNT_W(6)) dut (
    .sclk (sclk),
    .re   (re),
    .bus  (bus)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {bus.data_out, bus.sout_valid, bus.frame_start, bus.busy, bus.done};
  endfunction

  // Cycle i = sample taken after the i-th edge following the edge that samples start.
  task automatic run_frame(input string tag, input logic [0:W-1] p, input logic epar,
                           input int late_at, input logic [0:W-1] p_late,
                           input int restart_at);
    logic [NC-1:0] av, ad, af, ab, adn, ev, ed, ef, eb, edn;
    @(negedge sclk);
    bus.phi_in = p;
    bus.start  = 1'b1;
    for (int i = 0; i < int'(NC); i++) begin
      @(negedge sclk);
      av[i]  = bus.sout_valid;
      ad[i]  = bus.data_out;
      af[i]  = bus.frame_start;
      ab[i]  = bus.busy;
      adn[i] = bus.done;
      bus.start = (i == restart_at);
      if (i == late_at) bus.phi_in = p_late;
    end
    bus.start = 1'b0;
    for (int i = 0; i < int'(NC); i++) begin
      ev[i]  = (i >= 1 && i <= 62);
      eb[i]  = (i >= 1 && i <= 62);
      ef[i]  = (i == 1);
      edn[i] = (i == 63);
      if (i == 1)                ed[i] = 1'b1;
      else if (i >= 2 && i <= 61) ed[i] = p[i-2];
      else if (i == 62)          ed[i] = epar;
      else                       ed[i] = 1'b0;
    end
    check({tag, "_valid"}, 256'(av), 256'(ev));
    check({tag, "_data"},  256'(ad), 256'(ed));
    check({tag, "_fs"},    256'(af), 256'(ef));
    check({tag, "_busy"},  256'(ab), 256'(eb));
    check({tag, "_done"},  256'(adn), 256'(edn));
  endtask

  initial begin : main
    logic [0:W-1] p, r;
    logic [NB-1:0] bv, bd, bf, bdn, ev, ed, ef, edn;
    logic          found, seen;
    total = 0;
    bad   = 0;

    re         = 1'b1;
    bus.start  = 1'b0;
    bus.phi_in = '0;
    repeat (3) @(negedge sclk);
    check("reset_outs", 256'(outs()), 256'(0));
    re = 1'b0;
    @(negedge sclk);
    check("idle_outs", 256'(outs()), 256'(0));

    // Single set bit at index 0; extra start mid-frame is ignored
    p = {1'b1, 59'b0};
    run_frame("one_hot", p, 1'b1, -1, '0, 10);

    // All ones: even count of ones -> parity 0; start landing in DONE ignored
    p = '1;
    run_frame("all_ones", p, 1'b0, -1, '0, 62);

    // 1011_0010 pattern; phi_in flips to all ones mid-frame without effect
    p = {8'b1011_0010, 52'b0};
    run_frame("pattern", p, 1'b0, 5, '1, -1);

    // Odd ones count near the tail end of the vector
    p = {57'b0, 3'b111};
    run_frame("tail3", p, 1'b1, -1, '0, -1);

    // Back-to-back frames with start held high for NB cycles
    p = {8'b1011_0010, 52'b0};
    @(negedge sclk);
    bus.phi_in = p;
    bus.start  = 1'b1;
    for (int i = 0; i < int'(NB); i++) begin
      @(negedge sclk);
      bv[i]  = bus.sout_valid;
      bd[i]  = bus.data_out;
      bf[i]  = bus.frame_start;
      bdn[i] = bus.done;
    end
    bus.start = 1'b0;
    for (int i = 0; i < int'(NB); i++) begin
      int q;
      q      = (i - 1) % 64;
      ev[i]  = (i >= 1) && (q < 62);
      ef[i]  = (i >= 1) && (q == 0);
      edn[i] = (i >= 1) && (q == 62);
      if (i < 1 || q >= 62) ed[i] = 1'b0;
      else if (q == 0)      ed[i] = 1'b1;
      else if (q <= 60)     ed[i] = p[q-1];
      else                  ed[i] = 1'b0;
    end
    check("b2b_valid", 256'(bv), 256'(ev));
    check("b2b_fs",    256'(bf), 256'(ef));
    check("b2b_data",  256'(bd), 256'(ed));
    check("b2b_done",  256'(bdn), 256'(edn));
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge sclk);
      if (bus.done) found = 1'b1;
    end
    check("b2b_tail_done", 256'(found), 256'(1));
    @(negedge sclk);
    check("b2b_tail_idle", 256'(outs()), 256'(0));

    // Reset while data bit 30 is on the line
    r = W'({$urandom(), $urandom()});
    @(negedge sclk);
    bus.phi_in = r;
    bus.start  = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      @(negedge sclk);
      bus.start = 1'b0;
    end
    check("mid_bit30", 256'({bus.sout_valid, bus.data_out}), 256'({1'b1, r[30]}));
    re = 1'b1;
    #1;
    check("mid_reset_outs", 256'(outs()), 256'(0));
    for (int i = 0; i < 3; i++) begin
      bus.start  = 1'($urandom());
      bus.phi_in = W'({$urandom(), $urandom()});
      @(negedge sclk);
      check("hold_reset_outs", 256'(outs()), 256'(0));
    end
    bus.start = 1'b0;
    re = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge sclk);
      seen = seen | bus.sout_valid | bus.done | bus.busy;
    end
    check("post_reset_quiet", 256'(seen), 256'(0));

    r = W'({$urandom(), $urandom()});
    run_frame("after_reset", r, ^r, -1, '0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
